dvs_fifo_bus_arbiter: RTL



---
 rtl/dvs_ravens_pkg.sv | 10 +
 rtl/dvs_fifo_bus_arbiter_if.sv | 29 ++
 rtl/dvs_fifo_bus_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dvs_ravens_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dvs_ravens_pkg
//  Brief    : Shared widths for the DVS event path.
//  Revision : 1.0  initial release
// ============================================================================
package dvs_ravens_pkg;
    localparam int EVENT_BITS = 32;
endpackage
`default_nettype wire

// File: rtl/dvs_fifo_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dvs_fifo_bus_arbiter_if
//  Brief    : Requester request/grant/write bus plus the event FIFO write port.
//  Revision : 1.0  initial release
// ============================================================================
interface dvs_fifo_bus_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int EVENT_BITS = dvs_ravens_pkg::EVENT_BITS
);
    logic [NUM_REQ-1:0]            fifo_req;
    logic [NUM_REQ-1:0]            fifo_wr_en_in;
    logic [NUM_REQ*EVENT_BITS-1:0] fifo_event_in;
    logic                          fifo_pop;
    logic [NUM_REQ-1:0]            fifo_grant;
    logic                          out_wr_en;
    logic [EVENT_BITS-1:0]         out_event;

    modport master (
        output fifo_req, fifo_wr_en_in, fifo_event_in, fifo_pop,
        input  fifo_grant, out_wr_en, out_event
    );

    modport slave (
        input  fifo_req, fifo_wr_en_in, fifo_event_in, fifo_pop,
        output fifo_grant, out_wr_en, out_event
    );
endinterface
`default_nettype wire

// File: rtl/dvs_fifo_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dvs_fifo_bus_arbiter
//  Brief    : Credit-throttled round-robin arbiter sharing one event FIFO write
//             port between NUM_REQ requesters. Optional credit-stall counter
//             enabled by defining DVS_FIFO_ARB_STALL_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module dvs_fifo_bus_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int EVENT_BITS = dvs_ravens_pkg::EVENT_BITS,
    localparam int c_CREDIT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    dvs_fifo_bus_arbiter_if.slave      bus,
    output logic [c_CREDIT_W-1:0]      credits,
    output logic                       bus_err,
    output logic [15:0]                stall_count
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [c_PTR_W-1:0] ptr_t;

    localparam ptr_t                   c_PTR_RST  = ptr_t'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]     c_ONE_HOT0 = NUM_REQ'(1);
    localparam logic [c_CREDIT_W-1:0]  c_FULL     = c_CREDIT_W'(FIFO_DEPTH);
    localparam logic [c_CREDIT_W-1:0]  c_CRED_ONE = c_CREDIT_W'(1);

    logic [NUM_REQ-1:0]     r_grant;
    ptr_t                   r_ptr;
    ptr_t                   r_wr_sel;
    ptr_t                   r_wr_sel_d;
    logic                   r_exp_vld;
    logic                   r_out_wr_en;
    logic [EVENT_BITS-1:0]  r_out_event;
    logic [c_CREDIT_W-1:0]  r_credits;
    logic                   r_bus_err;

    logic [NUM_REQ-1:0]     w_elig;
    logic [NUM_REQ-1:0]     w_rot;
    logic                   w_found;
    ptr_t                   w_sel;
    logic                   w_issue;
    logic [NUM_REQ-1:0]     w_grant_oh;
    logic [NUM_REQ-1:0]     w_exp_oh;
    logic                   w_wr_ok;
    logic                   w_wr_bad;
    logic [c_CREDIT_W-1:0]  w_credits_nxt;
    logic                   w_pop_err;
    logic [EVENT_BITS-1:0]  w_ev [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ev_slice
        assign w_ev[g] = bus.fifo_event_in[g*EVENT_BITS +: EVENT_BITS];
    end

    // Rotate the eligible set so bit 0 is the requester just after the pointer.
    always_comb begin
        w_elig     = bus.fifo_req & ~r_grant;
        w_rot      = NUM_REQ'({w_elig, w_elig} >> (int'(r_ptr) + 1));
        w_found    = 1'b0;
        w_sel      = r_ptr;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_sel   = ptr_t'((int'(r_ptr) + 1 + j) % NUM_REQ);
            end
        end
        w_issue    = w_found && (r_credits != '0);
        w_grant_oh = w_issue ? (c_ONE_HOT0 << w_sel) : '0;
    end

    // Only the requester granted two cycles ago may write; anything else is dropped.
    always_comb begin
        w_exp_oh = r_exp_vld ? (c_ONE_HOT0 << r_wr_sel_d) : '0;
        w_wr_ok  = r_exp_vld && bus.fifo_wr_en_in[r_wr_sel_d];
        w_wr_bad = |(bus.fifo_wr_en_in & ~w_exp_oh);
    end

    always_comb begin
        w_credits_nxt = r_credits;
        w_pop_err     = 1'b0;
        if (w_issue && !bus.fifo_pop) begin
            w_credits_nxt = r_credits - c_CRED_ONE;
        end else if (!w_issue && bus.fifo_pop) begin
            if (r_credits == c_FULL) begin
                w_pop_err = 1'b1;
            end else begin
                w_credits_nxt = r_credits + c_CRED_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= '0;
            r_ptr       <= c_PTR_RST;
            r_wr_sel    <= '0;
            r_wr_sel_d  <= '0;
            r_exp_vld   <= 1'b0;
            r_out_wr_en <= 1'b0;
            r_out_event <= '0;
            r_credits   <= c_FULL;
            r_bus_err   <= 1'b0;
        end else begin
            r_grant     <= w_grant_oh;
            if (w_issue) begin
                r_ptr    <= w_sel;
                r_wr_sel <= w_sel;
            end
            r_wr_sel_d  <= r_wr_sel;
            r_exp_vld   <= |r_grant;
            r_out_wr_en <= w_wr_ok;
            if (w_wr_ok) begin
                r_out_event <= w_ev[r_wr_sel_d];
            end
            r_credits   <= w_credits_nxt;
            r_bus_err   <= r_bus_err | w_wr_bad | w_pop_err;
        end
    end

`ifdef DVS_FIFO_ARB_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if ((|w_elig) && (r_credits == '0) && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_count = r_stall;
`else
    assign stall_count = 16'd0;
`endif

    assign bus.fifo_grant = r_grant;
    assign bus.out_wr_en  = r_out_wr_en;
    assign bus.out_event  = r_out_event;
    assign credits        = r_credits;
    assign bus_err        = r_bus_err;

endmodule
`default_nettype wire
